// File: rtl/fetch_prefetch_stage.sv
// Fetch stage with a DEPTH-entry prefetch queue of {instr, pc, npc} feeding decode.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_prefetch_stage #(
  parameter int DEPTH = 4,
  parameter int WORD_W = 32,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       CLK,
  input  logic                       nRST,
  output logic                       imemREN,
  output logic [WORD_W-1:0]          imemaddr,
  input  logic                       ihit,
  input  logic [WORD_W-1:0]          instr,
  input  logic                       redirect,
  input  logic [WORD_W-1:0]          redirect_pc,
  input  logic                       stall,
  input  logic                       halt,
  output logic                       out_valid,
  output logic [WORD_W-1:0]          out_instr,
  output logic [WORD_W-1:0]          out_pc,
  output logic [WORD_W-1:0]          out_npc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [15:0]                perf_flush_cnt,
  output logic [15:0]                perf_full_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WORD_W-1:0] instr_q [DEPTH];
  logic [WORD_W-1:0] pc_q    [DEPTH];
  logic [WORD_W-1:0] npc_q   [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [WORD_W-1:0] fetch_pc, pc_plus4;
  logic              full, push, pop;
  logic              unused_redirect_lsbs;

  // Word alignment of the redirect target drops the low two bits.
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign full      = (count == FULL_CNT);
  assign pc_plus4  = fetch_pc + WORD_W'(4);
  assign imemREN   = !full && !redirect && !halt;
  assign imemaddr  = fetch_pc;
  assign push      = imemREN && ihit;
  assign out_valid = (count != '0);
  assign pop       = out_valid && !stall;

  assign out_instr = instr_q[rptr];
  assign out_pc    = pc_q[rptr];
  assign out_npc   = npc_q[rptr];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_pc <= RESET_PC;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[WORD_W-1:2], 2'b00};
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= pc_plus4;
        wptr     <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first fill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        npc_q[i]   <= '0;
      end
    end else if (push) begin
      instr_q[wptr] <= instr;
      pc_q[wptr]    <= fetch_pc;
      npc_q[wptr]   <= pc_plus4;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] flush_cnt_q, full_cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      flush_cnt_q <= '0;
      full_cnt_q  <= '0;
    end else begin
      if (redirect && out_valid && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
      if (full && (full_cnt_q != 16'hFFFF)) begin
        full_cnt_q <= full_cnt_q + 16'd1;
      end
    end
  end

  assign perf_flush_cnt = flush_cnt_q;
  assign perf_full_cnt  = full_cnt_q;
`else
  assign perf_flush_cnt = 16'd0;
  assign perf_full_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Directed bench for fetch_prefetch_stage (DEPTH=4, RESET_PC=0); expected values are hand-derived.
module tb_fetch_prefetch_stage;
  localparam int DEPTH = 4;
  localparam int WORD_W = 32;
  localparam logic [31:0] IBASE = 32'hA000_0000;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] instr;
  logic              redirect;
  logic [WORD_W-1:0] redirect_pc;
  logic              stall;
  logic              halt;
  logic              out_valid;
  logic [WORD_W-1:0] out_instr, out_pc, out_npc;
  logic [2:0]        count;
  logic [15:0]       perf_flush_cnt, perf_full_cnt;

  int total = 0;
  int bad = 0;
  int pops;
  logic [31:0] exp_pc;
  logic [31:0] exp_flush;

  fetch_prefetch_stage #(.DEPTH(DEPTH), .WORD_W(WORD_W), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .instr(instr), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .halt(halt), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_npc(out_npc), .count(count),
    .perf_flush_cnt(perf_flush_cnt), .perf_full_cnt(perf_full_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Flushes the queue and restarts fetch at the given target.
  task automatic do_redirect(input logic [31:0] target);
    redirect = 1'b1;
    redirect_pc = target;
    step();
    redirect = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; instr = '0; redirect = 1'b0;
    redirect_pc = '0; stall = 1'b0; halt = 1'b0;
    #12;
    check_output("rst_count", 32'(count), 32'd0);
    check_output("rst_valid", 32'(out_valid), 32'd0);
    check_output("rst_out_pc", out_pc, 32'd0);
    check_output("rst_addr", imemaddr, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Streaming: one push and one pop per cycle keeps a single entry.
    ihit = 1'b1;
    instr = IBASE;
    #1;
    check_output("stream_addr0", imemaddr, 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      instr = IBASE + 32'(4 * (k + 1));
      check_output("stream_addr", imemaddr, 32'(4 * (k + 1)));
      check_output("stream_pc", out_pc, 32'(4 * k));
      check_output("stream_npc", out_npc, 32'(4 * k + 4));
      check_output("stream_instr", out_instr, IBASE + 32'(4 * k));
      check_output("stream_count", 32'(count), 32'd1);
    end

    // Fill under stall until full.
    do_redirect(32'h0);
    check_output("fill_flush_count", 32'(count), 32'd0);
    check_output("fill_flush_valid", 32'(out_valid), 32'd0);
    check_output("fill_flush_addr", imemaddr, 32'h0);
    stall = 1'b1;
    instr = IBASE;
    for (int i = 1; i <= 4; i++) begin
      step();
      instr = IBASE + 32'(4 * i);
      check_output("fill_count", 32'(count), 32'(i));
    end
    check_output("full_ren", 32'(imemREN), 32'd0);
    check_output("full_addr", imemaddr, 32'h10);
    step();
    check_output("full_hold_count", 32'(count), 32'd4);
    check_output("full_hold_addr", imemaddr, 32'h10);
    stall = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check_output("drain_pc", out_pc, 32'(4 * j));
      check_output("drain_instr", out_instr, IBASE + 32'(4 * j));
      step();
      instr = IBASE + 32'h10 + 32'(4 * j);
      if (j == 0) begin
        check_output("drain_count", 32'(count), 32'd3);
        check_output("resume_ren", 32'(imemREN), 32'd1);
        check_output("resume_addr", imemaddr, 32'h10);
      end
    end

    // Redirect with three entries queued and an ihit that must be dropped.
    do_redirect(32'h0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr = IBASE + 32'(4 * i);
      step();
    end
    check_output("pre_redir_count", 32'(count), 32'd3);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    instr = 32'hDEAD_BEEF;
    #1;
    check_output("redir_ren", 32'(imemREN), 32'd0);
    step();
    redirect = 1'b0;
    check_output("redir_count", 32'(count), 32'd0);
    check_output("redir_valid", 32'(out_valid), 32'd0);
    check_output("redir_addr", imemaddr, 32'h100);
`ifdef FETCH_PERF_EN
    exp_flush = 32'd3;
`else
    exp_flush = 32'd0;
`endif
    check_output("perf_flush", 32'(perf_flush_cnt), exp_flush);
    stall = 1'b0;
    instr = IBASE + 32'h100;
    step();
    check_output("redir_new_pc", out_pc, 32'h100);
    check_output("redir_new_instr", out_instr, IBASE + 32'h100);

    // Mixed push/pop pattern to wrap the pointers several times.
    do_redirect(32'h0);
    pops = 0;
    exp_pc = 32'h0;
    for (int c = 0; c < 80 && pops < 10; c++) begin
      stall = (c % 3 == 1);
      ihit = (c % 4 != 3);
      instr = 32'h0;
      #1;
      if (out_valid && !stall) begin
        check_output("wrap_pc", out_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      step();
    end
    if (pops < 10) check_output("wrap_timeout", 32'(pops), 32'd10);

    // Halt with two queued entries: fetch stops, queue drains.
    stall = 1'b0; ihit = 1'b1;
    do_redirect(32'h0);
    stall = 1'b1;
    step();
    step();
    check_output("halt_pre_count", 32'(count), 32'd2);
    halt = 1'b1;
    stall = 1'b0;
    #1;
    check_output("halt_ren", 32'(imemREN), 32'd0);
    check_output("halt_addr", imemaddr, 32'h8);
    step();
    check_output("halt_count1", 32'(count), 32'd1);
    check_output("halt_pc1", out_pc, 32'h4);
    step();
    check_output("halt_count0", 32'(count), 32'd0);
    step();
    check_output("halt_stay_count", 32'(count), 32'd0);
    check_output("halt_stay_valid", 32'(out_valid), 32'd0);
    check_output("halt_stay_addr", imemaddr, 32'h8);

    // Asynchronous reset mid-stream with three entries.
    halt = 1'b0;
    do_redirect(32'h40);
    stall = 1'b1;
    step();
    step();
    step();
    check_output("prerst_count", 32'(count), 32'd3);
    #2;
    nRST = 1'b0;
    #1;
    check_output("async_count", 32'(count), 32'd0);
    check_output("async_valid", 32'(out_valid), 32'd0);
    check_output("async_addr", imemaddr, 32'h0);
    check_output("async_out_pc", out_pc, 32'h0);
    check_output("async_flush_perf", 32'(perf_flush_cnt), 32'd0);
    check_output("async_full_perf", 32'(perf_full_cnt), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
